// File: rtl/cordic_engine_if.sv
// cordic_engine_if: sample-in / result-out handshake bundle for cordic_engine.
// The master side feeds operands and accepts results; the engine is the slave.
interface cordic_engine_if #(
    parameter int XY_SZ  = 16,
    parameter int ANG_SZ = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic signed [XY_SZ-1:0] in_x;
    logic signed [XY_SZ-1:0] in_y;
    logic [ANG_SZ-1:0]       in_angle;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_mode;
    logic signed [XY_SZ+1:0] out_x;
    logic signed [XY_SZ+1:0] out_y;
    logic [ANG_SZ-1:0]       out_z;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_angle, out_ready,
        input  in_ready, out_valid, out_mode, out_x, out_y, out_z
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_angle, out_ready,
        output in_ready, out_valid, out_mode, out_x, out_y, out_z
    );
endinterface

// File: rtl/cordic_engine.sv
// cordic_engine: pipelined rotation/vectoring CORDIC with a global-stall handshake.
// Define CORDIC_GAIN_COMP_EN to append a registered 1/K gain-compensation stage.
module cordic_engine #(
    parameter int XY_SZ  = 16,
    parameter int ANG_SZ = 32,
    parameter int STG    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    cordic_engine_if.slave   io
);
    localparam int W = XY_SZ + 2;
    localparam int A = ANG_SZ;
    // round(atan(2^-i) * 2^32 / 2pi), rescaled to A bits at use
    localparam logic [31:0] ATAN32 [30] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4, 32'h028B0D43,
        32'h0145D7E1, 32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2F,
        32'h000A2F98, 32'h000517CC, 32'h00028BE6, 32'h000145F3, 32'h0000A2FA,
        32'h0000517D, 32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051, 32'h00000029,
        32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001
    };

    logic                valid_q [STG+1];
    logic                valid_d [STG+1];
    logic                mode_q  [STG+1];
    logic                mode_d  [STG+1];
    logic signed [W-1:0] x_q     [STG+1];
    logic signed [W-1:0] x_d     [STG+1];
    logic signed [W-1:0] y_q     [STG+1];
    logic signed [W-1:0] y_d     [STG+1];
    logic [A-1:0]        z_q     [STG+1];
    logic [A-1:0]        z_d     [STG+1];
    logic                dir     [STG];
    logic signed [W-1:0] ix, iy;
    logic [1:0]          q;
    logic                ce;

    assign ce          = !io.out_valid || io.out_ready;
    assign io.in_ready = ce;

    always_comb begin
        ix = {{2{io.in_x[XY_SZ-1]}}, io.in_x};
        iy = {{2{io.in_y[XY_SZ-1]}}, io.in_y};
        q = io.in_angle[A-1 -: 2];
        valid_d[0] = io.in_valid;
        mode_d[0] = io.in_mode;
        if (io.in_mode) begin
            x_d[0] = !ix[W-1] ? ix : !iy[W-1] ? iy : -iy;
            y_d[0] = !ix[W-1] ? iy : !iy[W-1] ? -ix : ix;
            z_d[0] = ix[W-1] ? {iy[W-1], 1'b1, {(A-2){1'b0}}} : '0;
        end else begin
            x_d[0] = q == 2'b01 ? -iy : q == 2'b10 ? iy : ix;
            y_d[0] = q == 2'b01 ? ix : q == 2'b10 ? -ix : iy;
            z_d[0] = (q[1] ^ q[0]) ? {q[1], q[1], io.in_angle[A-3:0]} : io.in_angle;
        end
        for (int i = 0; i < STG; i++) begin
            dir[i] = mode_q[i] ? !y_q[i][W-1] : z_q[i][A-1];
            valid_d[i+1] = valid_q[i];
            mode_d[i+1] = mode_q[i];
            x_d[i+1] = dir[i] ? x_q[i] + (y_q[i] >>> i) : x_q[i] - (y_q[i] >>> i);
            y_d[i+1] = dir[i] ? y_q[i] - (x_q[i] >>> i) : y_q[i] + (x_q[i] >>> i);
            z_d[i+1] = dir[i] ? z_q[i] + A'(ATAN32[i] >> (32 - A)) : z_q[i] - A'(ATAN32[i] >> (32 - A));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= '{default: 1'b0};
            mode_q <= '{default: 1'b0};
            x_q <= '{default: '0};
            y_q <= '{default: '0};
            z_q <= '{default: '0};
        end else if (ce) begin
            valid_q <= valid_d;
            mode_q <= mode_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13, each term floored
    function automatic logic signed [W-1:0] inv_k(input logic signed [W-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
    endfunction

    logic                g_valid_q, g_valid_d, g_mode_q, g_mode_d;
    logic signed [W-1:0] g_x_q, g_x_d, g_y_q, g_y_d;
    logic [A-1:0]        g_z_q, g_z_d;

    always_comb begin
        g_valid_d = valid_q[STG];
        g_mode_d = mode_q[STG];
        g_x_d = inv_k(x_q[STG]);
        g_y_d = inv_k(y_q[STG]);
        g_z_d = z_q[STG];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            g_valid_q <= 1'b0;
            g_mode_q <= 1'b0;
            g_x_q <= '0;
            g_y_q <= '0;
            g_z_q <= '0;
        end else if (ce) begin
            g_valid_q <= g_valid_d;
            g_mode_q <= g_mode_d;
            g_x_q <= g_x_d;
            g_y_q <= g_y_d;
            g_z_q <= g_z_d;
        end
    end

    assign io.out_valid = g_valid_q;
    assign io.out_mode  = g_mode_q;
    assign io.out_x     = g_x_q;
    assign io.out_y     = g_y_q;
    assign io.out_z     = g_z_q;
`else
    assign io.out_valid = valid_q[STG];
    assign io.out_mode  = mode_q[STG];
    assign io.out_x     = x_q[STG];
    assign io.out_y     = y_q[STG];
    assign io.out_z     = z_q[STG];
`endif
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: scoreboard bench for cordic_engine (16/32/16, default build),
// an arithmetic reference model plus hand-derived literal expectations.
module tb_cordic_engine;
    localparam int LAT = 17;

    typedef struct packed {
        logic        m;
        logic [17:0] x;
        logic [17:0] y;
        logic [31:0] z;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   n_out = 0;
    int   en_cnt = 0;
    logic [31:0]        atan_ref [16];
    logic signed [17:0] last_x, last_y;
    logic [31:0]        last_z;
    res_t               sb [$];
    int                 stamp_q [$];

    always #5 clk = ~clk;

    cordic_engine_if #(.XY_SZ(16), .ANG_SZ(32)) io ();

    cordic_engine #(.XY_SZ(16), .ANG_SZ(32), .STG(16)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .io      (io.slave)
    );

    task automatic chk(input string name, input longint act, input longint exp, input longint tol);
        compared++;
        if (act - exp > tol || exp - act > tol) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic res_t cordic_ref(input logic m, input logic signed [15:0] xi, input logic signed [15:0] yi,
                                        input logic [31:0] a);
        longint x, y, t;
        logic [31:0] z;
        logic d;
        x = xi;
        y = yi;
        z = a;
        if (m) begin
            if (x >= 0) z = 32'h0;
            else if (y >= 0) begin t = x; x = y; y = -t; z = 32'h40000000; end
            else begin t = x; x = -y; y = t; z = 32'hC0000000; end
        end else if (a[31:30] == 2'b01) begin
            t = x; x = -y; y = t; z = {2'b00, a[29:0]};
        end else if (a[31:30] == 2'b10) begin
            t = x; x = y; y = -t; z = {2'b11, a[29:0]};
        end
        for (int i = 0; i < 16; i++) begin
            d = m ? (y >= 0) : z[31];
            t = x;
            if (d) begin
                x = x + (y >>> i); y = y - (t >>> i); z = z + atan_ref[i];
            end else begin
                x = x - (y >>> i); y = y + (t >>> i); z = z - atan_ref[i];
            end
        end
        return {m, x[17:0], y[17:0], z};
    endfunction

    task automatic put(input logic m, input logic signed [15:0] x, input logic signed [15:0] y, input logic [31:0] a);
        logic acc;
        io.in_valid = 1'b1;
        io.in_mode = m;
        io.in_x = x;
        io.in_y = y;
        io.in_angle = a;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            acc = io.in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        chk("put_timeout", 0, 1, 0);
    endtask

    task automatic run_one(input logic m, input logic signed [15:0] x, input logic signed [15:0] y, input logic [31:0] a);
        int n0;
        n0 = n_out;
        put(m, x, y, a);
        io.in_valid = 1'b0;
        for (int c = 0; c < 60 && n_out == n0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("result_timeout", n_out - n0, 1, 0);
    endtask

    initial begin
        res_t r;
        int   n0;
        io.in_valid = 1'b0;
        io.in_mode = 1'b0;
        io.in_x = '0;
        io.in_y = '0;
        io.in_angle = '0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            atan_ref[i] = 32'($rtoi($atan(2.0 ** (-i)) * 4294967296.0 / (2.0 * 3.141592653589793) + 0.5));

        fork
            begin : monitor
                logic held;
                logic [69:0] hv;
                res_t e;
                held = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!reset_n) begin
                        sb.delete();
                        stamp_q.delete();
                        held = 1'b0;
                    end else begin
                        if (held)
                            chk_eq("stall_hold", {io.out_valid, io.out_mode, io.out_x, io.out_y, io.out_z}, hv);
                        if (io.out_valid && !io.out_ready)
                            chk("stall_in_ready", io.in_ready, 0, 0);
                        held = io.out_valid && !io.out_ready;
                        hv = {io.out_valid, io.out_mode, io.out_x, io.out_y, io.out_z};
                        if (io.out_valid && io.out_ready) begin
                            if (sb.size() == 0) begin
                                compared++;
                                mismatched++;
                                $display("FAIL stale_result: got x=%0d y=%0d z=%h with nothing outstanding",
                                         io.out_x, io.out_y, io.out_z);
                            end else begin
                                e = sb.pop_front();
                                chk_eq("result", {io.out_mode, io.out_x, io.out_y, io.out_z}, e);
                                chk("latency", en_cnt - stamp_q.pop_front(), LAT, 0);
                            end
                            last_x = io.out_x;
                            last_y = io.out_y;
                            last_z = io.out_z;
                            n_out++;
                        end
                        if (io.in_valid && io.in_ready) begin
                            sb.push_back(cordic_ref(io.in_mode, io.in_x, io.in_y, io.in_angle));
                            stamp_q.push_back(en_cnt);
                        end
                        if (io.in_ready) en_cnt++;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_outputs", {io.out_valid, io.out_mode, io.out_x, io.out_y, io.out_z}, '0);
        chk("reset_in_ready", io.in_ready, 1, 0);
        reset_n = 1'b1;

        chk("atan0", atan_ref[0], 32'h20000000, 0);
        chk("atan1", atan_ref[1], 32'h12E4051E, 0);

        // rotate (16384,0) by 45 degrees
        r = cordic_ref(1'b0, 16'sd16384, 16'sd0, 32'h20000000);
        chk("model_rot45_x", $signed(r.x), 19079, 4);
        run_one(1'b0, 16'sd16384, 16'sd0, 32'h20000000);
        chk("rot45_x", last_x, 19079, 4);
        chk("rot45_y", last_y, 19079, 4);
        chk("rot45_z", longint'($signed(last_z)), 0, 32'h0000FFFF);

        // rotate (10000,0) by 135 degrees
        r = cordic_ref(1'b0, 16'sd10000, 16'sd0, 32'h60000000);
        chk("model_rot135_y", $signed(r.y), 11645, 4);
        run_one(1'b0, 16'sd10000, 16'sd0, 32'h60000000);
        chk("rot135_x", last_x, -11645, 4);
        chk("rot135_y", last_y, 11645, 4);

        // vector (-10000,0)
        run_one(1'b1, -16'sd10000, 16'sd0, 32'h0);
        chk("vec_neg_x", last_x, 16468, 4);
        chk("vec_neg_y", last_y, 0, 2);
        chk("vec_neg_z", longint'($signed(last_z - 32'h80000000)), 0, 32'h10000);

        // vector (-32768,-32768)
        r = cordic_ref(1'b1, -16'sd32768, -16'sd32768, 32'h0);
        chk("model_vecmin_x", $signed(r.x), 76318, 8);
        run_one(1'b1, -16'sd32768, -16'sd32768, 32'h0);
        chk("vec_min_x", last_x, 76318, 8);
        chk("vec_min_z", longint'($signed(last_z - 32'hA0000000)), 0, 32'h10000);

        // 40-sample mixed stream with a 5-cycle downstream stall
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 40; k++)
                    put(k[0] ^ k[3], (k == 0) ? -16'sd32768 : 16'(k * 1637 - 31000),
                        (k == 0) ? -16'sd32768 : 16'(k * 2741 - 28000), 32'(k) * 32'h0C8F5C29);
                io.in_valid = 1'b0;
            end
            begin
                repeat (22) @(posedge clk);
                #1;
                io.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                io.out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("stream_count", n_out - n0, 40, 0);

        // reset with 10 samples in flight
        for (int k = 0; k < 10; k++)
            put(k[0], 16'(k * 3001 - 15000), 16'(12000 - k * 2203), 32'(k) * 32'h1999999A);
        io.in_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_eq("inflight_reset_outputs", {io.out_valid, io.out_mode, io.out_x, io.out_y, io.out_z}, '0);
        n0 = n_out;
        repeat (30) @(posedge clk);
        #1;
        chk("no_stale_after_reset", n_out - n0, 0, 0);
        run_one(1'b0, 16'sd16384, 16'sd0, 32'hE0000000);
        chk("post_reset_x", last_x, 19079, 4);
        chk("post_reset_y", last_y, -19079, 4);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
